// File: rtl/vga_timing_pkg.sv
// Purpose: shared VGA timing constants and helpers.
//   - DEF_*      : 640x480@60 porch/sync defaults (pixels / lines)
//   - POL_*      : sync polarity constants (active-low / active-high)
//   - axis_total : total pixels per line or lines per frame
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CW       = 11;

  localparam logic POL_LOW  = 1'b0;
  localparam logic POL_HIGH = 1'b1;

  // Sum of the four segments of one axis.
  function automatic int axis_total(input int act, input int fp,
                                    input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  // Horizontal total (pixels per line).
  function automatic int h_total(input int act, input int fp,
                                 input int sync, input int bp);
    return axis_total(act, fp, sync, bp);
  endfunction

  // Vertical total (lines per frame).
  function automatic int v_total(input int act, input int fp,
                                 input int sync, input int bp);
    return axis_total(act, fp, sync, bp);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Purpose: raster-timing bundle between the pixel-tick source / consumer
//   (master) and the sync generator (slave).
//   pix_en      : pixel tick, master -> slave
//   hsync/vsync : sync levels, slave -> master
//   active      : visible-area flag
//   x/y         : current pixel coordinates
//   line_start  : 1-clk pulse when x becomes 0
//   frame_start : 1-clk pulse when (x,y) becomes (0,0)
interface vga_sync_gen_if #(
  parameter int CW = 11
);
  logic          pix_en;
  logic          hsync;
  logic          vsync;
  logic          active;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          line_start;
  logic          frame_start;

  modport master (
    output pix_en,
    input  hsync, vsync, active, x, y, line_start, frame_start
  );

  modport slave (
    input  pix_en,
    output hsync, vsync, active, x, y, line_start, frame_start
  );
endinterface

// File: rtl/vga_axis_cnt.sv
// Purpose: one raster axis (horizontal or vertical). Counts 0..TOTAL-1,
//   advancing on adv, and registers the visible/sync decodes from the
//   next-state count so they line up with cnt_o.
//   clk, reset : system clock, synchronous active-high reset
//   adv        : advance by one position
//   cnt_o      : current count
//   wrap_o     : count sits at TOTAL-1 (next advance wraps to 0)
//   in_active_o: count is inside the visible segment
//   sync_o     : sync level (POL inside the pulse, ~POL elsewhere)
module vga_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter int   ACTIVE = DEF_H_ACTIVE,
  parameter int   FP     = DEF_H_FP,
  parameter int   SYNC   = DEF_H_SYNC,
  parameter int   BP     = DEF_H_BP,
  parameter logic POL    = POL_LOW,
  parameter int   CW     = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          adv,
  output logic [CW-1:0] cnt_o,
  output logic          wrap_o,
  output logic          in_active_o,
  output logic          sync_o
);

  localparam int            TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);
  localparam logic [CW-1:0] ONE        = CW'(1);
  localparam logic [CW-1:0] ZERO       = CW'(0);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          act_q, act_d;
  logic          sync_q, sync_d;

  assign wrap_o      = (cnt_q == LAST);
  assign cnt_o       = cnt_q;
  assign in_active_o = act_q;
  assign sync_o      = sync_q;

  // Next count and the decodes of that next count.
  always_comb begin
    cnt_d = cnt_q;
    if (adv) begin
      if (wrap_o) begin
        cnt_d = ZERO;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
    act_d  = (cnt_d < ACT_END);
    sync_d = ((cnt_d >= SYNC_START) && (cnt_d < SYNC_END)) ? POL : ~POL;
  end

  // Counter and decode registers; reset parks on the last back-porch slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= LAST;
      act_q  <= 1'b0;
      sync_q <= ~POL;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      sync_q <= sync_d;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Purpose: VGA raster timing generator driven by a pixel-clock enable.
//   clk   : system clock
//   reset : synchronous active-high reset (wins over pix_en)
//   bus   : vga_sync_gen_if slave (pix_en in; hsync, vsync, active, x, y,
//           line_start, frame_start out)
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = POL_LOW,
  parameter logic VS_POL   = POL_LOW,
  parameter int   CW       = DEF_CW
) (
  input logic           clk,
  input logic           reset,
  vga_sync_gen_if.slave bus
);

  logic          h_wrap, v_wrap;
  logic          h_act, v_act;
  logic          h_sync, v_sync;
  logic [CW-1:0] h_cnt, v_cnt;
  logic          v_adv;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  // Lines advance only on the tick that wraps the pixel counter.
  assign v_adv = bus.pix_en & h_wrap;

  vga_axis_cnt #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .POL(HS_POL), .CW(CW)
  ) u_h_cnt (
    .clk(clk), .reset(reset), .adv(bus.pix_en),
    .cnt_o(h_cnt), .wrap_o(h_wrap), .in_active_o(h_act), .sync_o(h_sync)
  );

  vga_axis_cnt #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .POL(VS_POL), .CW(CW)
  ) u_v_cnt (
    .clk(clk), .reset(reset), .adv(v_adv),
    .cnt_o(v_cnt), .wrap_o(v_wrap), .in_active_o(v_act), .sync_o(v_sync)
  );

  // Pulses fire only on the advancing edge; any other edge clears them.
  always_comb begin
    line_start_d  = v_adv;
    frame_start_d = v_adv & v_wrap;
  end

  // Start-pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.x           = h_cnt;
  assign bus.y           = v_cnt;
  assign bus.hsync       = h_sync;
  assign bus.vsync       = v_sync;
  assign bus.active      = h_act & v_act;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Purpose: self-checking bench for vga_sync_gen. A small-parameter instance
//   is checked cycle by cycle against a behavioural raster model through a
//   scoreboard queue; a default-parameter instance is checked over two lines.
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  typedef struct {
    int x; int y; int hs; int vs; int act; int ls; int fs;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic reset_d;
  always #5 clk = ~clk;

  vga_sync_gen_if #(.CW(11)) bus ();
  vga_sync_gen_if #(.CW(11)) bus_d ();

  vga_sync_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(11)
  ) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  vga_sync_gen u_dut_def (
    .clk(clk), .reset(reset_d), .bus(bus_d)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  int   mh, mv, mls, mfs;
  int   cyc = 0;
  int   ls_period = 0, fs_period = 0;
  int   last_ls = -1, last_fs = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Advance the reference model for one clock edge and queue its outputs.
  task automatic model_push(input logic pe, input logic rst);
    exp_t e;
    if (rst) begin
      mh = HT - 1; mv = VT - 1; mls = 0; mfs = 0;
    end else if (pe) begin
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      mls = (mh == 0) ? 1 : 0;
      mfs = (mh == 0 && mv == 0) ? 1 : 0;
    end else begin
      mls = 0; mfs = 0;
    end
    e.x   = mh;
    e.y   = mv;
    e.hs  = (mh >= HA + HF && mh < HA + HF + HS) ? 0 : 1;
    e.vs  = (mv >= VA + VF && mv < VA + VF + VS) ? 0 : 1;
    e.act = (mh < HA && mv < VA) ? 1 : 0;
    e.ls  = mls;
    e.fs  = mfs;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation and compare the DUT against it.
  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("x", 32'(bus.x), 32'(e.x));
    chk("y", 32'(bus.y), 32'(e.y));
    chk("hsync", 32'(bus.hsync), 32'(e.hs));
    chk("vsync", 32'(bus.vsync), 32'(e.vs));
    chk("active", 32'(bus.active), 32'(e.act));
    chk("line_start", 32'(bus.line_start), 32'(e.ls));
    chk("frame_start", 32'(bus.frame_start), 32'(e.fs));
    if (ls_period != 0 && bus.line_start === 1'b1) begin
      if (last_ls >= 0) chk("ls_period", 32'(cyc - last_ls), 32'(ls_period));
      last_ls = cyc;
    end
    if (fs_period != 0 && bus.frame_start === 1'b1) begin
      if (last_fs >= 0) chk("fs_period", 32'(cyc - last_fs), 32'(fs_period));
      last_fs = cyc;
    end
  endtask

  // One clock: drive inputs at negedge, queue expectation, check after posedge.
  task automatic step(input logic pe, input logic rst);
    @(negedge clk);
    bus.pix_en = pe;
    reset      = rst;
    model_push(pe, rst);
    @(posedge clk);
    #1;
    cyc++;
    check_out();
  endtask

  initial begin
    int dh, dv, dls, dfs;
    reset       = 1'b1;
    reset_d     = 1'b1;
    bus.pix_en  = 1'b0;
    bus_d.pix_en = 1'b1;
    mh = 0; mv = 0; mls = 0; mfs = 0;

    // Reset held 3 clocks with pix_en high.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    chk("rst_x", 32'(bus.x), 32'd7);
    chk("rst_y", 32'(bus.y), 32'd5);

    // First tick after release lands on (0,0) with both pulses.
    step(1'b1, 1'b0);
    chk("first_fs", 32'(bus.frame_start), 32'd1);
    step(1'b0, 1'b0);
    chk("hold_x", 32'(bus.x), 32'd0);

    // Full-rate operation.
    ls_period = 8; fs_period = 48; last_ls = -1; last_fs = -1;
    for (int i = 0; i < 110; i++) step(1'b1, 1'b0);

    // 1-in-4 pixel tick.
    ls_period = 32; fs_period = 192; last_ls = -1; last_fs = -1;
    for (int i = 0; i < 420; i++) step((i % 4) == 3, 1'b0);

    // Reset mid-frame at (2,1).
    ls_period = 0; fs_period = 0;
    for (int i = 0; i < 60 && !(mh == 2 && mv == 1); i++) step(1'b1, 1'b0);
    chk("reach_x2y1", 32'((mh == 2 && mv == 1) ? 1 : 0), 32'd1);
    step(1'b1, 1'b1);
    chk("midrst_x", 32'(bus.x), 32'd7);
    chk("midrst_y", 32'(bus.y), 32'd5);
    step(1'b1, 1'b0);
    chk("midrst_fs", 32'(bus.frame_start), 32'd1);

    // Default 640x480 timing over two lines plus margin.
    chk("def_rst_x", 32'(bus_d.x), 32'd799);
    chk("def_rst_y", 32'(bus_d.y), 32'd524);
    chk("def_rst_hs", 32'(bus_d.hsync), 32'd1);
    @(negedge clk);
    reset_d = 1'b0;
    dh = 799; dv = 524;
    for (int i = 0; i < 1700; i++) begin
      @(posedge clk);
      #1;
      if (dh == 799) begin
        dh = 0;
        dv = (dv == 524) ? 0 : dv + 1;
      end else begin
        dh = dh + 1;
      end
      dls = (dh == 0) ? 1 : 0;
      dfs = (dh == 0 && dv == 0) ? 1 : 0;
      chk("def_x", 32'(bus_d.x), 32'(dh));
      chk("def_y", 32'(bus_d.y), 32'(dv));
      chk("def_hsync", 32'(bus_d.hsync), 32'((dh >= 656 && dh < 752) ? 0 : 1));
      chk("def_vsync", 32'(bus_d.vsync), 32'((dv >= 490 && dv < 492) ? 0 : 1));
      chk("def_active", 32'(bus_d.active), 32'((dh < 640 && dv < 480) ? 1 : 0));
      chk("def_ls", 32'(bus_d.line_start), 32'(dls));
      chk("def_fs", 32'(bus_d.frame_start), 32'(dfs));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
VGA raster timing generator that consumes the periodic tick from the programmable clock-divider counter (its c_int output) as a pixel-clock enable. It produces hsync, vsync, display-enable and pixel coordinates for the pattern and pixel logic downstream. Everything runs on the single system clock. Counters advance only on enabled cycles.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)
CW, 11, coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
pix_en  input  1  pixel tick (driven from the divider's c_int); advance one pixel when high
hsync  output  1  horizontal sync, polarity per HS_POL
vsync  output  1  vertical sync, polarity per VS_POL
active  output  1  high while (x,y) is inside the visible area
x  output  CW  current horizontal count h_cnt
y  output  CW  current vertical count v_cnt
line_start  output  1  one-clk pulse when h_cnt becomes 0
frame_start  output  1  one-clk pulse when (h_cnt,v_cnt) becomes (0,0)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Reset (sync, active-high, priority over pix_en):
  - h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1 (last back-porch pixel).
  - hsync = ~HS_POL, vsync = ~VS_POL, active = 0, line_start = 0, frame_start = 0.
  - x and y equal the counters.
- Clock edge with pix_en=1 and reset=0:
  - h_cnt wraps H_TOTAL-1 -> 0, otherwise increments by 1.
  - v_cnt advances only when h_cnt wraps; it wraps V_TOTAL-1 -> 0, otherwise increments by 1.
- Clock edge with pix_en=0: counters and level outputs hold.
- Outputs are registered and decoded from the next-state counters, so they are aligned with x/y in the same cycle (zero latency relative to the counters).
  - active = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hsync = HS_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; otherwise ~HS_POL.
  - vsync = VS_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC; otherwise ~VS_POL. The whole line counts, not pixel-aligned.
- line_start and frame_start:
  - Set on the edge where the new h_cnt is 0 (respectively, new h,v are both 0) with pix_en=1.
  - Cleared on the next clk edge regardless of pix_en, so each pulse is exactly 1 clk wide even when pix_en is gated.
- pix_en held constantly high gives full-rate operation.
- Reset asserted mid-frame returns to the reset state on that edge. The first pix_en after release produces (0,0) with frame_start=1.

Decomposition:
- Package vga_timing_pkg:
  - default 640x480@60 porch/sync constants;
  - H_TOTAL/V_TOTAL derivation functions;
  - a polarity constant pair.
- Sub-module vga_axis_cnt, instantiated twice (horizontal, vertical):
  - inputs: parameters ACTIVE/FP/SYNC/BP/POL, clk, reset, adv.
  - outputs: cnt, wrap, in_active, sync.
  - h instance: adv = pix_en; v instance: adv = pix_en & h wrap.

Test Plan:
Small params unless stated: H=4/1/2/1 (H_TOTAL 8), V=3/1/1/1 (V_TOTAL 6), polarities 0.
- Reset held 3 clks with pix_en=1 -> x=7, y=5, hsync=1, vsync=1, active=0, both pulses 0.
- Release reset, one pix_en -> next cycle x=0, y=0, active=1, line_start=1, frame_start=1. Next clk with pix_en=0 -> pulses both 0, x=0 held.
- pix_en constant 1 -> hsync low exactly at x=5,6 (2 clks per 8). active high at x=0..3 on y=0..2 only. line_start every 8 clks.
- pix_en constant 1 -> vsync low for all 8 pixels of y=4. frame_start every 48 clks.
- pix_en = 1-in-4 tick (divider val=3) -> outputs change only on tick edges. Frame period 192 clks. frame_start still 1 clk wide.
- Reset asserted at x=2, y=1 with pix_en=1 -> next cycle x=7, y=5, syncs inactive (reset beats pix_en).
- Default params, pix_en=1 -> frame_start period 420000 clks; hsync low at x=656..751; vsync low at y=490..491.
